// File: rtl/user_neopixel_pkg.sv
// Shared definitions for the WS2812 neopixel subordinate: register map, status layout,
// FSM state encoding and the OBI subordinate request/response types.
package user_neopixel_pkg;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiIdWidth   = 4;

  // Size of the address window owned by this block; offsets past the register file error out.
  localparam int unsigned WindowBits = 12;

  localparam logic [3:0] RegCtrl     = 4'h0;
  localparam logic [3:0] RegStatus   = 4'h4;
  localparam logic [3:0] RegData     = 4'h8;
  localparam logic [3:0] RegReserved = 4'hC;

  localparam int unsigned CtrlEnableBit   = 0;
  localparam int unsigned CtrlOvfClrBit   = 1;
  localparam int unsigned StatusBusyBit   = 0;
  localparam int unsigned StatusFullBit   = 1;
  localparam int unsigned StatusOvfBit    = 2;
  localparam int unsigned StatusFillLsb   = 8;
  localparam int unsigned StatusFillWidth = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } np_state_e;

  typedef struct packed {
    logic [ObiAddrWidth-1:0] addr;
    logic                    we;
    logic [3:0]              be;
    logic [ObiDataWidth-1:0] wdata;
    logic [ObiIdWidth-1:0]   aid;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic [ObiIdWidth-1:0]   rid;
    logic                    err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } sbr_obi_rsp_t;

  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                              input logic ovf,
                                              input logic [StatusFillWidth-1:0] fill);
    logic [31:0] s;
    s = '0;
    s[StatusBusyBit] = busy;
    s[StatusFullBit] = full;
    s[StatusOvfBit]  = ovf;
    s[StatusFillLsb +: StatusFillWidth] = fill;
    return s;
  endfunction

endpackage

// File: rtl/user_neopixel_fifo.sv
// Pixel FIFO with first-word visible on data_out (no fall-through); a push on a full
// FIFO is still accepted when a pop happens in the same cycle.
module user_neopixel_fifo
  import user_neopixel_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [Width-1:0]           data_in,
  output logic [Width-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth):0]     fill
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0]   FullCount = (PtrW+1)'(Depth);
  localparam logic [PtrW:0]   CountOne  = (PtrW+1)'(1);
  localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_reg;
  logic [PtrW-1:0]  rd_ptr_reg;
  logic [PtrW:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == FullCount);
  assign fill     = count_reg;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PtrOne;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PtrOne;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CountOne;
        2'b01:   count_reg <= count_reg - CountOne;
        default: ;
      endcase
    end
  end

  // Storage carries no reset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= data_in;
  end

endmodule

// File: rtl/user_neopixel.sv
// OBI subordinate that queues 24-bit GRB pixels and serialises them onto a WS2812 data
// line, MSB first, closing each frame with a low latch gap.
module user_neopixel
  import user_neopixel_pkg::*;
#(
  parameter int unsigned FifoDepth   = 8,
  parameter int unsigned BitCycles   = 25,
  parameter int unsigned T0hCycles   = 8,
  parameter int unsigned T1hCycles   = 16,
  parameter int unsigned LatchCycles = 1200
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  sbr_obi_req_t obi_req_i,
  output sbr_obi_rsp_t obi_rsp_o,
  output logic         neopixel_data_o
);

  localparam int unsigned CntW  = $clog2(LatchCycles + 1);
  localparam int unsigned FillW = $clog2(FifoDepth) + 1;
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] BitLast   = CntW'(BitCycles - 1);
  localparam logic [CntW-1:0] LatchLast = CntW'(LatchCycles - 1);
  localparam logic [CntW-1:0] T0h       = CntW'(T0hCycles);
  localparam logic [CntW-1:0] T1h       = CntW'(T1hCycles);

  logic                  req;
  logic                  we;
  logic [3:0]            reg_off;
  logic                  addr_err;
  logic                  wr_ctrl;
  logic                  push;
  logic                  pop;
  logic                  ovf_set;
  logic [31:0]           read_data;

  logic [23:0]           fifo_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FillW-1:0]      fifo_fill;

  logic                  enable_reg;
  logic                  overflow_reg;
  logic                  rvalid_reg;
  logic [ObiIdWidth-1:0] rid_reg;
  logic [31:0]           rdata_reg;
  logic                  err_reg;

  np_state_e             state_reg;
  logic [23:0]           shift_reg;
  logic [4:0]            bit_idx_reg;
  logic [CntW-1:0]       cnt_reg;
  logic                  data_reg;
  logic [CntW-1:0]       high_len;
  logic                  bit_end;
  logic                  unused;

  assign req      = obi_req_i.req;
  assign we       = obi_req_i.a.we;
  assign reg_off  = {obi_req_i.a.addr[3:2], 2'b00};
  assign addr_err = |obi_req_i.a.addr[WindowBits-1:4];
  assign wr_ctrl  = req && we && !addr_err && (reg_off == RegCtrl);
  assign push     = req && we && !addr_err && (reg_off == RegData);
  assign ovf_set  = push && fifo_full && !pop;
  assign unused   = ^{obi_req_i.a.be, obi_req_i.a.addr[ObiAddrWidth-1:WindowBits],
                      obi_req_i.a.addr[1:0], obi_req_i.a.wdata[31:24]};

  user_neopixel_fifo #(
    .Depth (FifoDepth),
    .Width (24)
  ) i_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (push),
    .pop      (pop),
    .data_in  (obi_req_i.a.wdata[23:0]),
    .data_out (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .fill     (fifo_fill)
  );

  always_comb begin
    read_data = '0;
    if (!addr_err) begin
      case (reg_off)
        RegCtrl:   read_data[CtrlEnableBit] = enable_reg;
        RegStatus: read_data = pack_status(state_reg != IDLE, fifo_full, overflow_reg,
                                           StatusFillWidth'(fifo_fill));
        default:   read_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      rvalid_reg   <= 1'b0;
      rid_reg      <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      rvalid_reg <= req;
      if (req) begin
        rid_reg   <= obi_req_i.a.aid;
        rdata_reg <= we ? 32'h0 : read_data;
        err_reg   <= addr_err;
      end
      if (wr_ctrl) enable_reg <= obi_req_i.a.wdata[CtrlEnableBit];
      // A fresh overflow takes priority over a concurrent clear request.
      if (ovf_set)
        overflow_reg <= 1'b1;
      else if (wr_ctrl && obi_req_i.a.wdata[CtrlOvfClrBit])
        overflow_reg <= 1'b0;
    end
  end

  always_comb begin
    obi_rsp_o         = '0;
    obi_rsp_o.gnt     = req;
    obi_rsp_o.rvalid  = rvalid_reg;
    obi_rsp_o.r.rdata = rdata_reg;
    obi_rsp_o.r.rid   = rid_reg;
    obi_rsp_o.r.err   = err_reg;
  end

  assign high_len = shift_reg[23] ? T1h : T0h;
  assign bit_end  = (cnt_reg == BitLast);
  // A new pixel is taken from idle, or chained directly onto the last bit of the previous one.
  assign pop = enable_reg && !fifo_empty &&
               ((state_reg == IDLE) || (state_reg == LOW && bit_end && bit_idx_reg == 5'd0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      cnt_reg     <= '0;
      data_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
            shift_reg   <= fifo_data;
            bit_idx_reg <= 5'd23;
            cnt_reg     <= '0;
            data_reg    <= 1'b1;
            state_reg   <= HIGH;
          end
        end
        HIGH: begin
          cnt_reg <= cnt_reg + CntOne;
          if (cnt_reg + CntOne == high_len) begin
            data_reg  <= 1'b0;
            state_reg <= LOW;
          end
        end
        LOW: begin
          if (bit_end) begin
            cnt_reg <= '0;
            if (bit_idx_reg != 5'd0) begin
              shift_reg   <= {shift_reg[22:0], 1'b0};
              bit_idx_reg <= bit_idx_reg - 5'd1;
              data_reg    <= 1'b1;
              state_reg   <= HIGH;
            end else if (pop) begin
              shift_reg   <= fifo_data;
              bit_idx_reg <= 5'd23;
              data_reg    <= 1'b1;
              state_reg   <= HIGH;
            end else begin
              state_reg <= LATCH;
            end
          end else begin
            cnt_reg <= cnt_reg + CntOne;
          end
        end
        LATCH: begin
          if (cnt_reg == LatchLast) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CntOne;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign neopixel_data_o = data_reg;

endmodule
